// File: rtl/tag_retire_drain.sv
// Round-robin drain of a tagfile: find a valid entry, read it, present it, then invalidate it.
// Optional macro TAG_RETIRE_DRAIN_BUFFERED_READ_EN adds a WAIT state for tagfiles with registered read.
module tag_retire_drain #(
  parameter int unsigned addr_w = 5,
  parameter int unsigned data_w = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [2**addr_w-1:0] tag_vld_map,
  output logic [addr_w-1:0]    rd_addr,
  input  logic [data_w-1:0]    rd_data,
  output logic                 clr_en,
  output logic [addr_w-1:0]    clr_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [addr_w-1:0]    out_addr,
  output logic [data_w-1:0]    out_tag
);

  localparam int unsigned       num_ent    = 2**addr_w;
  localparam logic [addr_w-1:0] first_addr = addr_w'(1);
  localparam logic [addr_w-1:0] last_addr  = addr_w'(num_ent - 1);
  localparam logic [addr_w:0]   ent_cnt    = (addr_w+1)'(num_ent);
  localparam logic [addr_w:0]   wrap_sub   = (addr_w+1)'(num_ent - 1);

  typedef enum logic [2:0] {
    SEARCH  = 3'd0,
    READ    = 3'd1,
`ifdef TAG_RETIRE_DRAIN_BUFFERED_READ_EN
    WAIT    = 3'd2,
`endif
    PRESENT = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [addr_w-1:0]   ptr_q;
  logic [addr_w-1:0]   ptr_d;
  logic [addr_w-1:0]   rd_addr_d;
  logic                out_valid_d;
  logic [addr_w-1:0]   out_addr_d;
  logic [data_w-1:0]   out_tag_d;
  logic                clr_en_d;
  logic [addr_w-1:0]   clr_addr_d;

  logic                hit;
  logic [addr_w-1:0]   hit_addr;
  logic [addr_w:0]     cand;
  logic                rd_vld;

  // First set bit at or above ptr, scanning 1..num_ent-1 with wrap; entry 0 never qualifies.
  always_comb begin
    hit      = 1'b0;
    hit_addr = '0;
    cand     = '0;
    for (int unsigned i = 0; i < num_ent - 1; i++) begin
      cand = {1'b0, ptr_q} + (addr_w+1)'(i);
      if (cand >= ent_cnt) begin
        cand = cand - wrap_sub;
      end
      if (!hit && tag_vld_map[cand[addr_w-1:0]]) begin
        hit      = 1'b1;
        hit_addr = cand[addr_w-1:0];
      end
    end
  end

  // Entry under read may be invalidated by the tagfile before it is captured.
  assign rd_vld = tag_vld_map[rd_addr];

  // Next-state and next-output logic; flush overrides every state including a same-cycle handshake.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rd_addr_d   = rd_addr;
    out_valid_d = out_valid;
    out_addr_d  = out_addr;
    out_tag_d   = out_tag;
    clr_en_d    = 1'b0;
    clr_addr_d  = clr_addr;
    if (flush) begin
      state_d     = SEARCH;
      ptr_d       = first_addr;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (hit) begin
            rd_addr_d = hit_addr;
            state_d   = READ;
          end
        end
`ifdef TAG_RETIRE_DRAIN_BUFFERED_READ_EN
        READ: begin
          state_d = rd_vld ? WAIT : SEARCH;
        end
        WAIT: begin
          if (!rd_vld) begin
            state_d = SEARCH;
          end else begin
            out_tag_d   = rd_data;
            out_addr_d  = rd_addr;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end
`else
        READ: begin
          if (!rd_vld) begin
            state_d = SEARCH;
          end else begin
            out_tag_d   = rd_data;
            out_addr_d  = rd_addr;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end
`endif
        PRESENT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            ptr_d       = (out_addr == last_addr) ? first_addr : out_addr + first_addr;
            clr_en_d    = 1'b1;
            clr_addr_d  = out_addr;
            state_d     = CLEAR;
          end
        end
        CLEAR: begin
          state_d = SEARCH;
        end
        default: begin
          state_d     = SEARCH;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      ptr_q     <= first_addr;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_tag   <= '0;
      clr_en    <= 1'b0;
      clr_addr  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_addr   <= rd_addr_d;
      out_valid <= out_valid_d;
      out_addr  <= out_addr_d;
      out_tag   <= out_tag_d;
      clr_en    <= clr_en_d;
      clr_addr  <= clr_addr_d;
    end
  end

endmodule

// File: tb/tb_tag_retire_drain.sv
// Bench for tag_retire_drain: a tagfile model plus a transaction-level reference of drain order,
// presentation hold, single-cycle clear, flush and reset behaviour.
module tb_tag_retire_drain;

  localparam int unsigned addr_w = 5;
  localparam int unsigned data_w = 32;
  localparam int N = 2**addr_w;
`ifdef TAG_RETIRE_DRAIN_BUFFERED_READ_EN
  localparam int lat = 3;
`else
  localparam int lat = 2;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                flush;
  logic                out_ready;
  logic [N-1:0]        vld;
  logic [addr_w-1:0]   rd_addr;
  logic [data_w-1:0]   rd_data;
  logic                clr_en;
  logic [addr_w-1:0]   clr_addr;
  logic                out_valid;
  logic [addr_w-1:0]   out_addr;
  logic [data_w-1:0]   out_tag;
  logic [data_w-1:0]   tags [N];

  int n_cmp;
  int n_err;
  int cyc;
  int mptr;
  int m_addr;
  logic [data_w-1:0] m_tag;
  logic prev_valid;
  logic prev_hs;
  logic prev_flush;
  logic pend_clr;
  logic [addr_w-1:0] pend_addr;
  logic [N-1:0] hist [$];
  int idle_cnt;

  always #5 clk = ~clk;

`ifdef TAG_RETIRE_DRAIN_BUFFERED_READ_EN
  always @(posedge clk) rd_data <= tags[rd_addr];
`else
  assign rd_data = tags[rd_addr];
`endif

  tag_retire_drain #(.addr_w(addr_w), .data_w(data_w)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .tag_vld_map(vld),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_tag    (out_tag)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Round-robin pick: first valid entry in ptr, ptr+1, ... wrapping over 1..N-1.
  function automatic int scan(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N - 1; k++) begin
      int a;
      a = ((p - 1 + k) % (N - 1)) + 1;
      if (m[a]) return a;
    end
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(vld);
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_flush = 1'b0;
    pend_clr   = 1'b0;
    mptr       = 1;
    m_addr     = 0;
    m_tag      = '0;
    idle_cnt   = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_clr_en",    64'(clr_en),    64'd0);
    check_eq("rst_rd_addr",   64'(rd_addr),   64'd0);
    check_eq("rst_out_addr",  64'(out_addr),  64'd0);
    check_eq("rst_out_tag",   64'(out_tag),   64'd0);
    check_eq("rst_clr_addr",  64'(clr_addr),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Start of a cycle: tagfile applies the clear strobed in the previous cycle.
  task automatic cyc_begin();
    @(posedge clk);
    #1;
    if (pend_clr) vld[pend_addr] = 1'b0;
    pend_clr = 1'b0;
  endtask

  // Middle of a cycle: compare DUT outputs with the reference and advance it.
  task automatic cyc_end();
    @(negedge clk);
    cyc++;
    hist.push_back(vld);
    if (hist.size() > 5) void'(hist.pop_front());
    if (prev_flush) begin
      check_eq("flush_valid", 64'(out_valid), 64'd0);
      check_eq("flush_clr",   64'(clr_en),    64'd0);
    end else if (prev_hs) begin
      check_eq("hs_valid",    64'(out_valid), 64'd0);
      check_eq("clr_en",      64'(clr_en),    64'd1);
      check_eq("clr_addr",    64'(clr_addr),  64'(m_addr));
    end else begin
      check_eq("no_clr",      64'(clr_en),    64'd0);
      if (prev_valid) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_addr",  64'(out_addr),  64'(m_addr));
        check_eq("hold_tag",   64'(out_tag),   64'(m_tag));
      end
    end
    if (out_valid && !prev_valid && !prev_flush && !prev_hs) begin
      if (hist.size() > lat) begin
        m_addr = scan(hist[hist.size()-1-lat], mptr);
        check_eq("pick_addr", 64'(out_addr), 64'(m_addr));
        if (m_addr > 0) begin
          check_eq("read_vld", 64'(hist[hist.size()-2][m_addr]), 64'd1);
          m_tag = tags[m_addr];
          check_eq("pick_tag", 64'(out_tag), 64'(m_tag));
        end
      end else begin
        m_addr = int'(out_addr);
        m_tag  = tags[m_addr];
      end
    end
    if (out_valid) check_eq("rd_addr_nz", 64'(rd_addr != '0), 64'd1);
    if (!out_valid && (|vld[N-1:1])) idle_cnt++;
    else idle_cnt = 0;
    if (idle_cnt > 10) begin
      check_eq("stall", 64'(out_valid), 64'd1);
      idle_cnt = 0;
    end
    if (clr_en) begin
      pend_clr  = 1'b1;
      pend_addr = clr_addr;
    end
    prev_hs = out_valid && out_ready && !flush;
    if (flush) mptr = 1;
    else if (prev_hs) mptr = (m_addr % (N - 1)) + 1;
    prev_flush = flush;
    prev_valid = out_valid && !flush && !prev_hs;
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic drain_one(output int a);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check_eq("drain_timeout", 64'(out_valid), 64'd1);
    a = int'(out_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int c0;
    int n;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    flush = 1'b0;
    out_ready = 1'b0;
    vld = '0;
    for (int i = 0; i < N; i++) tags[i] = '0;
    model_reset();
    #2;
    apply_reset();

    // Single entry: latency, value, one-cycle clear.
    cyc_begin(); vld[3] = 1'b1; tags[3] = 32'hDEADBEEF; out_ready = 1'b1; cyc_end();
    c0 = cyc;
    wait_valid(10);
    check_eq("t1_latency", 64'(cyc - c0), 64'(lat));
    check_eq("t1_addr", 64'(out_addr), 64'd3);
    check_eq("t1_tag",  64'(out_tag),  64'hDEADBEEF);
    tick();
    check_eq("t1_clr_en",   64'(clr_en),   64'd1);
    check_eq("t1_clr_addr", 64'(clr_addr), 64'd3);
    tick();
    check_eq("t1_clr_once", 64'(clr_en),   64'd0);

    // Move ptr to 8, then drain 2/7/31 in wrap order.
    cyc_begin(); vld[7] = 1'b1; tags[7] = $urandom; cyc_end();
    drain_one(a);
    check_eq("t2_first7", 64'(a), 64'd7);
    tick();
    cyc_begin();
    vld[2] = 1'b1; tags[2] = $urandom;
    vld[7] = 1'b1; tags[7] = $urandom;
    vld[31] = 1'b1; tags[31] = $urandom;
    cyc_end();
    drain_one(a); check_eq("t2_order0", 64'(a), 64'd31);
    drain_one(a); check_eq("t2_order1", 64'(a), 64'd2);
    drain_one(a); check_eq("t2_order2", 64'(a), 64'd7);
    repeat (2) tick();

    // Backpressure: hold address 5 for 10 cycles, then a single clear.
    cyc_begin(); vld[5] = 1'b1; tags[5] = $urandom; out_ready = 1'b0; cyc_end();
    wait_valid(10);
    check_eq("t3_addr", 64'(out_addr), 64'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t3_hold_tag", 64'(out_tag), 64'(tags[5]));
    end
    cyc_begin(); out_ready = 1'b1; cyc_end();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (clr_en) begin
        n++;
        check_eq("t3_clr_addr", 64'(clr_addr), 64'd5);
      end
    end
    check_eq("t3_clr_count", 64'(n), 64'd1);

    // Flush beats a same-cycle handshake; next search restarts at 1.
    cyc_begin(); vld[5] = 1'b1; vld[20] = 1'b1; tags[5] = $urandom; tags[20] = $urandom; out_ready = 1'b0; cyc_end();
    wait_valid(10);
    check_eq("t4_addr20", 64'(out_addr), 64'd20);
    cyc_begin(); flush = 1'b1; out_ready = 1'b1; cyc_end();
    cyc_begin(); flush = 1'b0; out_ready = 1'b0; cyc_end();
    check_eq("t4_valid_drop", 64'(out_valid), 64'd0);
    check_eq("t4_no_clr",     64'(clr_en),    64'd0);
    wait_valid(10);
    check_eq("t4_restart5", 64'(out_addr), 64'd5);
    cyc_begin(); out_ready = 1'b1; cyc_end();
    drain_one(a);
    check_eq("t4_then20", 64'(a), 64'd20);
    repeat (2) tick();

    // Entry invalidated while being read: abandoned silently.
    cyc_begin(); vld[4] = 1'b1; tags[4] = $urandom; cyc_end();
    cyc_begin(); vld[4] = 1'b0; cyc_end();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n += int'(out_valid) + int'(clr_en);
    end
    check_eq("t5_abort", 64'(n), 64'd0);

    // Reset during PRESENT: no clear, entry drained again afterwards.
    cyc_begin(); vld[9] = 1'b1; tags[9] = $urandom; out_ready = 1'b0; cyc_end();
    wait_valid(10);
    check_eq("t6_addr9", 64'(out_addr), 64'd9);
    apply_reset();
    cyc_begin(); out_ready = 1'b1; cyc_end();
    drain_one(a);
    check_eq("t6_redrain9", 64'(a), 64'd9);
    repeat (2) tick();

    // Reset during CLEAR: strobe dropped, entry survives.
    cyc_begin(); vld[11] = 1'b1; tags[11] = $urandom; cyc_end();
    n = 0;
    while (!clr_en && n < 20) begin
      tick();
      n++;
    end
    check_eq("t7_saw_clr", 64'(clr_en), 64'd1);
    apply_reset();
    drain_one(a);
    check_eq("t7_redrain11", 64'(a), 64'd11);
    repeat (2) tick();

    // Random traffic: revalidation, bit 0 noise, backpressure, occasional flush.
    for (int k = 0; k < 3000; k++) begin
      cyc_begin();
      if ($urandom_range(3) == 0) begin
        a = int'($urandom_range(N - 1, 1));
        if (!vld[a]) begin
          vld[a] = 1'b1;
          tags[a] = $urandom;
        end
      end
      vld[0] = 1'($urandom_range(1));
      out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(63) == 0);
      cyc_end();
    end
    cyc_begin(); flush = 1'b0; cyc_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tag_retire_drain.md
TAG_RETIRE_DRAIN -- requirements
Module: tag_retire_drain

Interface
REQ-001 SHALL have parameter addr_w, default 5, tagfile address width; address 0 is the hardwired null entry.
REQ-002 SHALL have parameter data_w, default 32, tag width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  in  1  synchronous abort of the drain in progress.
REQ-006 SHALL have port tag_vld_map  in  2**addr_w  per-address tag-valid bitmap from the tagfile; bit 0 ignored.
REQ-007 SHALL have port rd_addr  out  addr_w  tagfile read address, registered.
REQ-008 SHALL have port rd_data  in  data_w  tagfile read data for rd_addr.
REQ-009 SHALL have port clr_en  out  1  one-cycle invalidate strobe to the tagfile.
REQ-010 SHALL have port clr_addr  out  addr_w  address to invalidate, valid when clr_en=1.
REQ-011 SHALL have port out_valid  out  1  a retired tag is presented.
REQ-012 SHALL have port out_ready  in  1  consumer accepts the presented tag.
REQ-013 SHALL have port out_addr  out  addr_w  address of the presented tag.
REQ-014 SHALL have port out_tag  out  data_w  presented tag value.

Function
REQ-015 SHALL implement the FSM states SEARCH, READ, WAIT (only when REQ-029 applies), PRESENT and CLEAR.
REQ-016 In SEARCH, SHALL select the first set bit of tag_vld_map[2**addr_w-1:1] at or above a round-robin pointer ptr, wrapping from 2**addr_w-1 back to 1, load it into rd_addr and enter READ on the next edge.
REQ-017 In SEARCH, SHALL remain in SEARCH with all outputs idle when no bit in 1..2**addr_w-1 is set.
REQ-018 In READ, SHALL register rd_data into out_tag and rd_addr into out_addr, assert out_valid, and enter PRESENT; the search-to-out_valid latency is 2 cycles.
REQ-019 In READ or WAIT, if tag_vld_map[rd_addr] is 0, SHALL return to SEARCH without asserting out_valid or clr_en.
REQ-020 In PRESENT, SHALL hold out_valid, out_tag and out_addr stable until out_ready=1; out_valid never drops without a handshake, except on flush.
REQ-021 On the handshake (out_valid & out_ready), SHALL deassert out_valid, set ptr to out_addr+1 (wrapping 2**addr_w-1 -> 1) and enter CLEAR.
REQ-022 In CLEAR, SHALL assert clr_en=1 with clr_addr=out_addr for exactly one cycle, then enter SEARCH, so the next search sees the updated bitmap.
REQ-023 SHALL sustain at most one retired tag per 4 cycles (no macro) and SHALL never have two tags outstanding.
REQ-024 flush=1 in any state SHALL force SEARCH on the next edge, with out_valid=0, clr_en=0 and ptr=1; flush takes priority over a same-cycle handshake, so no clear is issued for that entry.
REQ-025 An entry re-validated by the tagfile after its clear SHALL be drained again as a new tag.
REQ-026 rd_addr SHALL never be driven to 0 in READ, WAIT or PRESENT.

Reset
REQ-027 While rst_n=0, SHALL set state=SEARCH, ptr=1, rd_addr=0, out_valid=0, out_addr=0, out_tag=0, clr_en=0 and clr_addr=0, asynchronously.
REQ-028 Reset asserted mid-PRESENT or mid-CLEAR SHALL drop out_valid and clr_en immediately and issue no clear for the abandoned entry.

Configuration
REQ-029 With macro TAG_RETIRE_DRAIN_BUFFERED_READ_EN defined, SHALL insert state WAIT between READ and PRESENT and capture rd_data in WAIT, matching a tagfile with registered read; the search-to-out_valid latency is 3 cycles.
REQ-030 Without TAG_RETIRE_DRAIN_BUFFERED_READ_EN, WAIT SHALL not exist and rd_data SHALL be captured in READ, as in REQ-018.

Verification
REQ-031 Set map bit 3 with tag 0xDEADBEEF and out_ready=1 -> out_valid at cycle +2, out_addr=3, out_tag=0xDEADBEEF, then clr_en=1 and clr_addr=3 for exactly 1 cycle.
REQ-032 Set map bits 2, 7 and 31 with ptr=8 -> drain order 31, 2, 7; ptr wraps to 1 after address 31.
REQ-033 Present address 5 with out_ready=0 for 10 cycles, then 1 -> out_tag stays stable for all cycles, and a single clr_en fires at addr 5.
REQ-034 Drive flush=1 and out_ready=1 in the same PRESENT cycle -> no clr_en, out_valid=0 next cycle, next search starts at address 1.
REQ-035 Clear map bit 4 while in READ -> no out_valid and no clr_en, FSM returns to SEARCH; also pulse rst_n low during PRESENT -> out_valid drops asynchronously.
REQ-036 With TAG_RETIRE_DRAIN_BUFFERED_READ_EN defined, rd_data delayed by one cycle -> out_valid at cycle +3 with the correct tag value.
